game_ctrl: RTL and testbench

Top-level sequencer for the breakout game. Owns game state (idle, serve, play, pause, over, win), the lives counter and the serve delay, and gates motion of paddle and ball. Sits between the debounced buttons and the paddle/ball/brick/score blocks, running on the 100 MHz master clock with a once-per-frame tick from the clock divider.

---
 rtl/game_ctrl.sv | 144 ++++++++++++++
 tb/tb_game_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Breakout game sequencer: state, lives, serve delay and motion gating; all outputs registered, one-cycle latency.
// Optional pause feature compiled in with `GAME_PAUSE_EN`.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       ball_lost,
  input  logic       brick_hit,
  input  logic       bricks_clear,
  output logic [2:0] state,
  output logic       run_en,
  output logic       serve,
  output logic       score_inc,
  output logic       score_clr,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       win
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4,
    S_WIN    = 3'd5
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic          start_q;
  logic          start_edge;

  assign start_edge = start & ~start_q;
  assign state      = st;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = pause & ~pause_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pause_q <= 1'b0;
    else      pause_q <= pause;
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_IDLE;
      cnt       <= '0;
      lives     <= 2'(LIVES);
      start_q   <= 1'b0;
      run_en    <= 1'b0;
      serve     <= 1'b0;
      score_inc <= 1'b0;
      score_clr <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      start_q   <= start;
      serve     <= 1'b0;
      score_inc <= 1'b0;
      score_clr <= 1'b0;
      case (st)
        S_IDLE, S_OVER, S_WIN: begin
          if (start_edge) begin
            st        <= S_SERVE;
            cnt       <= '0;
            lives     <= 2'(LIVES);
            serve     <= 1'b1;
            score_clr <= 1'b1;
            game_over <= 1'b0;
            win       <= 1'b0;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            if (cnt == CNT_LAST) begin
              st     <= S_PLAY;
              cnt    <= '0;
              run_en <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          // Scoring is independent of whatever transition happens this cycle.
          score_inc <= brick_hit;
          if (bricks_clear) begin
            st     <= S_WIN;
            run_en <= 1'b0;
            win    <= 1'b1;
          end else if (ball_lost && lives <= 2'd1) begin
            st        <= S_OVER;
            lives     <= 2'd0;
            run_en    <= 1'b0;
            game_over <= 1'b1;
          end else if (ball_lost) begin
            st     <= S_SERVE;
            lives  <= lives - 2'd1;
            serve  <= 1'b1;
            cnt    <= '0;
            run_en <= 1'b0;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_edge) begin
            st     <= S_PAUSED;
            run_en <= 1'b0;
          end
`endif
        end
`ifdef GAME_PAUSE_EN
        S_PAUSED: begin
          if (pause_edge) begin
            st     <= S_PLAY;
            run_en <= 1'b1;
          end
        end
`endif
        default: begin
          st        <= S_IDLE;
          cnt       <= '0;
          run_en    <= 1'b0;
          game_over <= 1'b0;
          win       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, serve delay, scoring, lives, win/over priority, pause, mid-game reset.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, start, pause, ball_lost, brick_hit, bricks_clear;
  logic [2:0] state;
  logic       run_en, serve, score_inc, score_clr, game_over, win;
  logic [1:0] lives;

  int checks = 0;
  int errors = 0;

  game_ctrl #(.LIVES(3), .SERVE_FRAMES(60)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
    .ball_lost(ball_lost), .brick_hit(brick_hit), .bricks_clear(bricks_clear),
    .state(state), .run_en(run_en), .serve(serve), .score_inc(score_inc),
    .score_clr(score_clr), .lives(lives), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds frame_tick high for exactly 60 cycles and confirms PLAY is entered.
  task automatic serve_to_play(input string tag);
    frame_tick = 1'b1;
    for (int i = 0; i < 60; i++) step();
    frame_tick = 1'b0;
    chk(tag, {5'd0, state}, 8'd2);
  endtask

  initial begin
    rst = 1'b0; frame_tick = 0; start = 0; pause = 0;
    ball_lost = 0; brick_hit = 0; bricks_clear = 0;
    step(); step();
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_lives", {6'd0, lives}, 8'd3);
    chk("rst_outs", {2'd0, run_en, serve, score_inc, score_clr, game_over, win}, 8'd0);

    rst = 1'b1;
    step();
    chk("idle_hold", {5'd0, state}, 8'd0);

    start = 1'b1;
    step();
    chk("start_state", {5'd0, state}, 8'd1);
    chk("start_pulses", {6'd0, serve, score_clr}, 8'b11);
    chk("start_lives", {6'd0, lives}, 8'd3);
    step();
    chk("start_held_once", {6'd0, serve, score_clr}, 8'b00);
    start = 1'b0;

    brick_hit = 1'b1; ball_lost = 1'b1;
    step();
    brick_hit = 1'b0; ball_lost = 1'b0;
    chk("serve_no_score", {7'd0, score_inc}, 8'd0);
    chk("serve_no_lost", {3'd0, state, lives}, {3'd0, 3'd1, 2'd3});

    // 59 ticks keeps SERVE, the 60th enters PLAY.
    for (int i = 0; i < 59; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
    chk("serve_59", {5'd0, state}, 8'd1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("serve_60", {6'd0, state[1:0]} | {run_en, 7'd0}, 8'h82);

    brick_hit = 1'b1; step();
    chk("hit1", {7'd0, score_inc}, 8'd1);
    step();
    chk("hit_b2b", {7'd0, score_inc}, 8'd1);
    brick_hit = 1'b0; step();
    chk("hit_end", {7'd0, score_inc}, 8'd0);

    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    chk("lost1", {2'd0, state, lives, serve}, {2'd0, 3'd1, 2'd2, 1'b1});
    chk("lost1_run", {7'd0, run_en}, 8'd0);
    serve_to_play("replay1");
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    chk("lost2", {2'd0, state, lives, serve}, {2'd0, 3'd1, 2'd1, 1'b1});
    serve_to_play("replay2");
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    chk("over", {1'd0, state, lives, game_over, serve}, {1'd0, 3'd4, 2'd0, 1'b1, 1'b0});
    chk("over_run", {7'd0, run_en}, 8'd0);
    step();
    chk("over_stays", {5'd0, state}, 8'd4);

    start = 1'b1; step(); start = 1'b0;
    chk("restart", {1'd0, state, lives, score_clr, game_over}, {1'd0, 3'd1, 2'd3, 1'b1, 1'b0});
    serve_to_play("replay3");

    ball_lost = 1'b1; bricks_clear = 1'b1; brick_hit = 1'b1;
    step();
    ball_lost = 1'b0; bricks_clear = 1'b0; brick_hit = 1'b0;
    chk("win", {1'd0, state, lives, win, score_inc}, {1'd0, 3'd5, 2'd3, 1'b1, 1'b1});
    chk("win_quiet", {5'd0, run_en, serve, game_over}, 8'd0);
    step();
    chk("win_pulse_end", {4'd0, state[2:0], score_inc}, {4'd0, 3'd5, 1'b0});

    start = 1'b1; step(); start = 1'b0;
    chk("win_restart", {3'd0, state, win, serve}, {3'd0, 3'd1, 1'b0, 1'b1});
    serve_to_play("replay4");

`ifdef GAME_PAUSE_EN
    pause = 1'b1; step();
    chk("paused", {4'd0, state, run_en}, {4'd0, 3'd3, 1'b0});
    ball_lost = 1'b1; brick_hit = 1'b1; step();
    ball_lost = 1'b0; brick_hit = 1'b0;
    chk("paused_ignore", {2'd0, state, lives, score_inc}, {2'd0, 3'd3, 2'd3, 1'b0});
    step();
    chk("paused_held", {5'd0, state}, 8'd3);
    pause = 1'b0; step();
    pause = 1'b1; step();
    chk("unpause", {4'd0, state, run_en}, {4'd0, 3'd2, 1'b1});
    pause = 1'b0; step();
`else
    pause = 1'b1; step(); step();
    chk("no_pause", {4'd0, state, run_en}, {4'd0, 3'd2, 1'b1});
    pause = 1'b0; step();
`endif

    // Lose a ball to get back into SERVE with serve pulsing, then reset mid-serve.
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    chk("pre_rst", {2'd0, state, lives, serve}, {2'd0, 3'd1, 2'd2, 1'b1});
    start = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_rst_state", {3'd0, state, lives}, {3'd0, 3'd0, 2'd3});
    chk("async_rst_outs", {2'd0, run_en, serve, score_inc, score_clr, game_over, win}, 8'd0);
    step(); step();
    chk("rst_held", {5'd0, state}, 8'd0);
    rst = 1'b1;
    step();
    chk("rel_start", {1'd0, state, lives, serve, score_clr}, {1'd0, 3'd1, 2'd3, 1'b1, 1'b1});
    start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
